// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared MAC types and width helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int MAC_DW = 8;
    localparam int PROD_W = 2 * MAC_DW + 1;

    function automatic int prod_width(input int dw);
        return 2 * dw + 1;
    endfunction

    // Wide enough that 2^LEN_W-1 products of full magnitude cannot overflow.
    function automatic int acc_width(input int dw, input int len_w);
        return 2 * dw + 1 + len_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_acc_drain.sv
// ============================================================================
// Module      : mac_acc_drain
// Description : Sums programmable-length groups of signed MAC products and
//               presents each group result over a valid/ready port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mac_acc_drain
    import mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LEN_W = 8,
    parameter int ACC_W = acc_width(DW, LEN_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*DW:0]        in_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_acc,
    output logic [15:0]          out_groups
);

    localparam int PW = prod_width(DW);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [15:0]        groups_q, groups_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               beat;
    logic [ACC_W-1:0]   prod_ext;
    logic [LEN_W-1:0]   len_first;
    logic [LEN_W-1:0]   cnt_inc;

    assign in_ready   = rst_n && in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_acc    = acc_q;
    assign out_groups = groups_q;

    assign beat      = in_valid && in_ready;
    assign prod_ext  = {{(ACC_W-PW){in_q[PW-1]}}, in_q};
    assign len_first = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign cnt_inc   = cnt_q + LEN_W'(1);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        groups_d = groups_q;

        if (flush) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat) begin
                        len_d   = len_first;
                        acc_d   = prod_ext;
                        cnt_d   = LEN_W'(1);
                        state_d = (len_first == LEN_W'(1)) ? ST_HOLD : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (beat) begin
                        acc_d = acc_q + prod_ext;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q && out_ready) begin
                        state_d  = ST_IDLE;
                        groups_d = groups_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Handshake flags are registered alongside the state they decode.
        out_valid_d = (state_d == ST_HOLD);
        in_ready_d  = (state_d != ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            groups_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            groups_q    <= groups_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_acc_drain.sv
// ============================================================================
// Module      : tb_mac_acc_drain
// Description : Self-checking bench for mac_acc_drain (DW=8, LEN_W=8).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mac_acc_drain;

    localparam int DW    = 8;
    localparam int LEN_W = 8;
    localparam int ACC_W = 25;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2*DW:0]     in_q = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_acc;
    logic [15:0]       out_groups;

    mac_acc_drain #(
        .DW    (DW),
        .LEN_W (LEN_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cfg_len    (cfg_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_q       (in_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_groups (out_groups)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cfg;
        int          n;
        logic [16:0] qa;
        logic [16:0] qb;
        logic [16:0] qc;
        logic [24:0] exp;
    } vec_t;

    vec_t        vecs[7];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [24:0] exp_q[$];
    logic [15:0] groups_model = '0;
    bit          rst_was_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor / scoreboard, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
                if (rst_was_low) begin
                    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
                    chk("rst_out_acc", {7'd0, out_acc}, 32'd0);
                    chk("rst_out_groups", {16'd0, out_groups}, 32'd0);
                end
                groups_model = '0;
                exp_q.delete();
            end else begin
                chk("out_groups", {16'd0, out_groups}, {16'd0, groups_model});
                if (out_valid && exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got out_acc 0x%0h with none expected at %0t", out_acc, $time);
                end else if (out_valid && out_ready) begin
                    chk("out_acc", {7'd0, out_acc}, {7'd0, exp_q.pop_front()});
                    if (!flush) groups_model = groups_model + 16'd1;
                end
            end
            rst_was_low = !rst_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [16:0] q);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_q     = q;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: got in_ready 0 for 50 cycles, required 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
            exp_q.delete();
        end
        chk("in_ready_after_result", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        cfg_len = v.cfg;
        for (int i = 0; i < v.n; i++) begin
            send_beat(i == 0 ? v.qa : (i == 1 ? v.qb : v.qc));
            // A change after the first beat must not affect this group.
            if (i == 0) cfg_len = ~v.cfg;
        end
        exp_q.push_back(v.exp);
        chk("valid_after_last", {31'd0, out_valid}, 32'd1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [24:0] sum;
        logic [16:0] q;

        vecs[0] = '{cfg: 8'd3,   n: 3,   qa: 17'd100,       qb: -17'sd50,     qc: 17'd7,        exp: 25'd57};
        vecs[1] = '{cfg: 8'd255, n: 255, qa: -17'sd16384,   qb: -17'sd16384,  qc: -17'sd16384,  exp: 25'h1C04000};
        vecs[2] = '{cfg: 8'd255, n: 255, qa: 17'd65025,     qb: 17'd65025,    qc: 17'd65025,    exp: 25'd16581375};
        vecs[3] = '{cfg: 8'd0,   n: 1,   qa: 17'h1FFFF,     qb: 17'd0,        qc: 17'd0,        exp: 25'h1FFFFFF};
        vecs[4] = '{cfg: 8'd1,   n: 1,   qa: 17'd12345,     qb: 17'd0,        qc: 17'd0,        exp: 25'd12345};
        vecs[5] = '{cfg: 8'd2,   n: 2,   qa: 17'h10000,     qb: 17'h10000,    qc: 17'd0,        exp: 25'h1FE0000};
        vecs[6] = '{cfg: 8'd4,   n: 4,   qa: 17'd1,         qb: 17'h1FFFF,    qc: 17'd3,        exp: 25'd6};

        repeat (4) @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Back-pressure: result held while a new beat waits at the input.
        out_ready = 1'b0;
        cfg_len   = 8'd2;
        send_beat(17'd10);
        send_beat(17'd20);
        exp_q.push_back(25'd30);
        cfg_len  = 8'd1;
        in_valid = 1'b1;
        in_q     = 17'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_acc", {7'd0, out_acc}, 32'd30);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_next_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(25'd5);
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Flush in the middle of a group, with a beat offered in the flush cycle.
        cfg_len = 8'd4;
        send_beat(17'd11);
        send_beat(17'd22);
        in_valid = 1'b1;
        in_q     = 17'd99;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_acc", {7'd0, out_acc}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (4) tick();
        run_vec('{cfg: 8'd2, n: 2, qa: 17'd3, qb: 17'd4, qc: 17'd0, exp: 25'd7});

        // Reset in the middle of a group.
        cfg_len = 8'd4;
        send_beat(17'd5);
        send_beat(17'd6);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_q     = 17'd7;
        repeat (3) tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        run_vec('{cfg: 8'd3, n: 3, qa: 17'd1, qb: 17'd2, qc: 17'd3, exp: 25'd6});

        // Pseudo-random group against a simple sign-extending sum.
        for (int g = 0; g < 3; g++) begin
            cfg_len = 8'd5;
            sum     = '0;
            for (int i = 0; i < 5; i++) begin
                q   = 17'($urandom_range(131071, 0));
                sum = sum + {{8{q[16]}}, q};
                send_beat(q);
                if (i == 0) cfg_len = 8'd1;
            end
            exp_q.push_back(sum);
            chk("rand_valid_after_last", {31'd0, out_valid}, 32'd1);
            drain();
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
